// File: rtl/mult_arbiter_if.sv
// Bundled requester, multiplier and response signals of mult_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mult_arbiter_if #(
    parameter int WIDTH = 16
);
    logic                 req0_valid;
    logic                 req1_valid;
    logic                 req0_ready;
    logic                 req1_ready;
    logic [2*WIDTH-1:0]   req0_a;
    logic [2*WIDTH-1:0]   req0_b;
    logic [2*WIDTH-1:0]   req1_a;
    logic [2*WIDTH-1:0]   req1_b;
    logic                 mul_in_en;
    logic [2*WIDTH-1:0]   mul_a;
    logic [2*WIDTH-1:0]   mul_b;
    logic                 mul_out_en;
    logic [2*WIDTH-1:0]   mul_c;
    logic                 rsp0_valid;
    logic                 rsp1_valid;
    logic [2*WIDTH-1:0]   rsp_c;
    logic                 busy;
    logic                 err;

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        input  mul_out_en, mul_c,
        output req0_ready, req1_ready, mul_in_en, mul_a, mul_b,
        output rsp0_valid, rsp1_valid, rsp_c, busy, err
    );

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        output mul_out_en, mul_c,
        input  req0_ready, req1_ready, mul_in_en, mul_a, mul_b,
        input  rsp0_valid, rsp1_valid, rsp_c, busy, err
    );
endinterface

// File: rtl/mult_arbiter.sv
// Two-requester arbiter in front of a shared fixed-latency complex multiplier.
// Define ARB_RR_EN for round-robin tie breaking; otherwise requester 0 has fixed priority.
module mult_arbiter #(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 3
) (
    input  logic          clock,
    input  logic          reset,
    mult_arbiter_if.slave bus
);
    localparam int CW = $clog2(LATENCY + 2);

    logic                 valid0;
    logic                 valid1;
    logic                 grant0;
    logic                 grant1;
    logic                 accept;
    logic [LATENCY-1:0]   tag_valid;
    logic [LATENCY-1:0]   tag_id;
    logic                 head_valid;
    logic                 head_id;
    logic                 deliver;
    logic [CW-1:0]        count;
    logic                 rsp0_valid_q;
    logic                 rsp1_valid_q;
    logic [2*WIDTH-1:0]   rsp_c_q;
    logic                 err_q;

    // Valids are masked during reset so nothing is granted while reset is high.
    assign valid0 = bus.req0_valid & ~reset;
    assign valid1 = bus.req1_valid & ~reset;

`ifdef ARB_RR_EN
    logic last_grant;

    always_comb begin
        grant0 = valid0 & (~valid1 | last_grant);
        grant1 = valid1 & (~valid0 | ~last_grant);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (grant0 | grant1) begin
            last_grant <= grant1;
        end
    end
`else
    always_comb begin
        grant0 = valid0;
        grant1 = valid1 & ~valid0;
    end
`endif

    assign accept         = grant0 | grant1;
    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.mul_in_en  = accept;

    always_comb begin
        bus.mul_a = '0;
        bus.mul_b = '0;
        if (grant0) begin
            bus.mul_a = bus.req0_a;
            bus.mul_b = bus.req0_b;
        end else if (grant1) begin
            bus.mul_a = bus.req1_a;
            bus.mul_b = bus.req1_b;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tag_valid <= '0;
            tag_id    <= '0;
        end else begin
            tag_valid[0] <= accept;
            tag_id[0]    <= grant1;
            for (int i = 1; i < LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_id[i]    <= tag_id[i-1];
            end
        end
    end

    assign head_valid = tag_valid[LATENCY-1];
    assign head_id    = tag_id[LATENCY-1];
    assign deliver    = bus.mul_out_en & head_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp_c_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            rsp0_valid_q <= deliver & ~head_id;
            rsp1_valid_q <= deliver & head_id;
            if (deliver) begin
                rsp_c_q <= bus.mul_c;
            end
            if (bus.mul_out_en ^ head_valid) begin
                err_q <= 1'b1;
            end
        end
    end

    // A head tag retires whether or not its product showed up, so a lost
    // product cannot leave busy stuck high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            case ({accept, head_valid})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp_c      = rsp_c_q;
    assign bus.busy       = (count != '0);
    assign bus.err        = err_q;
endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter with a behavioural Q1.15 complex multiplier.
// Expected products are hand-computed constants; a forked monitor pops and compares.
module tb_mult_arbiter;
    localparam int WIDTH   = 16;
    localparam int LATENCY = 3;
    localparam int W2      = 2 * WIDTH;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic force_oe = 1'b0;
    int   cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    mult_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mult_arbiter #(.WIDTH(WIDTH), .LATENCY(LATENCY)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Multiplier model, reset together with the arbiter.
    logic [LATENCY-1:0] pipe_en;
    logic [W2-1:0]      pipe_c [LATENCY];

    function automatic logic [W2-1:0] cmul(input logic [W2-1:0] a, input logic [W2-1:0] b);
        logic signed [63:0] ar, ai, br, bi, re, im;
        ar = 64'(signed'(a[W2-1:WIDTH]));
        ai = 64'(signed'(a[WIDTH-1:0]));
        br = 64'(signed'(b[W2-1:WIDTH]));
        bi = 64'(signed'(b[WIDTH-1:0]));
        re = (ar * br - ai * bi) >>> (WIDTH - 1);
        im = (ar * bi + ai * br) >>> (WIDTH - 1);
        return {re[WIDTH-1:0], im[WIDTH-1:0]};
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            pipe_en <= '0;
        end else begin
            pipe_en[0] <= bus.mul_in_en;
            pipe_c[0]  <= cmul(bus.mul_a, bus.mul_b);
            for (int i = 1; i < LATENCY; i++) begin
                pipe_en[i] <= pipe_en[i-1];
                pipe_c[i]  <= pipe_c[i-1];
            end
        end
    end

    assign bus.mul_out_en = pipe_en[LATENCY-1] | force_oe;
    assign bus.mul_c      = pipe_c[LATENCY-1];

    typedef struct {
        int            id;
        logic [W2-1:0] c;
        int            due;
    } exp_t;

    exp_t          sb[$];
    int            total = 0;
    int            bad = 0;
    logic [W2-1:0] p0;
    logic [W2-1:0] p1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One driving slot: set valids, check grants and the multiplier mux, log expectations.
    task automatic step(input bit v0, input bit v1, input bit e0, input bit e1);
        @(negedge clock);
        bus.req0_valid = v0;
        bus.req1_valid = v1;
        #1;
        check("req0_ready", bus.req0_ready, e0);
        check("req1_ready", bus.req1_ready, e1);
        check("mul_in_en", bus.mul_in_en, e0 | e1);
        if (!(e0 | e1)) begin
            check("mul_a_idle", bus.mul_a, 0);
            check("mul_b_idle", bus.mul_b, 0);
        end
        if (e0) sb.push_back('{id: 0, c: p0, due: cyc + LATENCY + 1});
        if (e1) sb.push_back('{id: 1, c: p1, due: cyc + LATENCY + 1});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    initial begin
        exp_t e;
        int   last_acc;
        bit   e0;

        bus.req0_valid = 0;
        bus.req1_valid = 0;
        bus.req0_a = '0;
        bus.req0_b = '0;
        bus.req1_a = '0;
        bus.req1_b = '0;
        p0 = '0;
        p1 = '0;

        fork
            forever begin
                @(negedge clock);
                if (bus.rsp0_valid || bus.rsp1_valid) begin
                    if (bus.rsp0_valid && bus.rsp1_valid) begin
                        check("rsp_both_valid", 1, 0);
                    end else if (sb.size() == 0) begin
                        check("rsp_unexpected", {bus.rsp1_valid, bus.rsp0_valid}, 0);
                    end else begin
                        e = sb.pop_front();
                        check("rsp_id", bus.rsp1_valid ? 1 : 0, e.id);
                        check("rsp_c", bus.rsp_c, e.c);
                        check("rsp_cycle", cyc, e.due);
                    end
                end
            end
        join_none

        // Reset state, including no grant while reset is high.
        repeat (2) @(negedge clock);
        bus.req0_valid = 1;
        bus.req1_valid = 1;
        #1;
        check("rst_req0_ready", bus.req0_ready, 0);
        check("rst_req1_ready", bus.req1_ready, 0);
        check("rst_rsp_c", bus.rsp_c, 0);
        check("rst_rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, 0);
        check("rst_err", bus.err, 0);
        check("rst_busy", bus.busy, 0);
        bus.req0_valid = 0;
        bus.req1_valid = 0;
        @(negedge clock);
        reset = 0;

        // 0.5 * 0.5 on requester 0
        bus.req0_a = 32'h4000_0000;
        bus.req0_b = 32'h4000_0000;
        p0 = 32'h2000_0000;
        step(1, 0, 1, 0);
        idle(6);

        // (0.5+0.5j)(0.5-0.5j) = 0.5 on requester 0
        bus.req0_a = 32'h4000_4000;
        bus.req0_b = 32'h4000_C000;
        p0 = 32'h4000_0000;
        step(1, 0, 1, 0);
        idle(6);

        // (0.5j)(0.5j) = -0.25 on requester 1; leaves the pointer at 1
        bus.req1_a = 32'h0000_4000;
        bus.req1_b = 32'h0000_4000;
        p1 = 32'hE000_0000;
        step(0, 1, 0, 1);
        idle(6);

        // Both requesters valid for 8 back-to-back cycles
        bus.req0_a = 32'h4000_0000;
        bus.req0_b = 32'h4000_0000;
        p0 = 32'h2000_0000;
        for (int i = 0; i < 8; i++) begin
`ifdef ARB_RR_EN
            e0 = (i % 2 == 0);
`else
            e0 = 1'b1;
`endif
            step(1, 1, e0, !e0);
            if (i > 0) check("busy_stream", bus.busy, 1);
        end
        last_acc = cyc;
        for (int k = 1; k <= 5; k++) begin
            step(0, 0, 0, 0);
            check("busy_drain", bus.busy, (cyc < last_acc + 4) ? 1 : 0);
        end
        idle(3);

        // Reset two cycles after two accepts; multiplier is reset along with it
        step(1, 0, 1, 0);
        step(0, 1, 0, 1);
        step(0, 0, 0, 0);
        @(negedge clock);
        reset = 1;
        sb.delete();
        @(negedge clock);
        @(negedge clock);
        reset = 0;
        #1;
        check("midrst_err", bus.err, 0);
        check("midrst_busy", bus.busy, 0);
        idle(8);
        check("midrst_err_later", bus.err, 0);

        // Stray mul_out_en with nothing in flight
        @(negedge clock);
        force_oe = 1;
        @(negedge clock);
        force_oe = 0;
        #1;
        check("err_set", bus.err, 1);
        idle(4);
        check("err_sticky", bus.err, 1);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clock);
        check("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, sample component width in bits (two's complement, Q1.(WIDTH-1)).
REQ-002 SHALL provide parameter LATENCY, default 3, fixed latency in cycles of the shared complex multiplier from in_en to out_en.
REQ-003 SHALL provide port clock  in  1  single clock; all logic on rising edge.
REQ-004 SHALL provide port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL provide ports req0_valid/req1_valid  in  1 each  requester operand valid.
REQ-006 SHALL provide ports req0_ready/req1_ready  out  1 each  operand accepted this cycle.
REQ-007 SHALL provide ports req0_a/req0_b/req1_a/req1_b  in  2*WIDTH each  packed {re[2W-1:W], im[W-1:0]} operands.
REQ-008 SHALL provide ports mul_in_en  out  1, and mul_a/mul_b  out  2*WIDTH each  packed operands driven to the shared multiplier.
REQ-009 SHALL provide ports mul_out_en  in  1, and mul_c  in  2*WIDTH  packed product returned by the multiplier.
REQ-010 SHALL provide ports rsp0_valid/rsp1_valid  out  1 each, and rsp_c  out  2*WIDTH  registered product routed to its owner.
REQ-011 SHALL provide ports busy  out  1  (products in flight) and err  out  1  (sticky protocol error).

Function
REQ-012 SHALL grant at most one requester per cycle; reqN_ready SHALL equal grantN, combinational from valids and pointer; no ready without valid.
REQ-013 SHALL, in build with ARB_RR_EN, grant the sole valid requester, or when both valid the one not granted last (1-bit last-grant pointer, updated on every grant, reset value 1 so requester 0 wins first tie).
REQ-014 SHALL drive mul_in_en = grant0|grant1 and mul_a/mul_b = granted requester's operands in the same cycle (zero-cycle mux); mul_a/mul_b SHALL be 0 when mul_in_en low.
REQ-015 SHALL push {valid=mul_in_en, id=granted index} into a LATENCY-deep tag shift register every cycle.
REQ-016 SHALL, on a cycle with mul_out_en high and head tag valid, register rsp_c <= mul_c and rspN_valid <= 1 for N = head id, other rsp valid 0; total accept-to-rsp latency LATENCY+1 cycles.
REQ-017 SHALL hold rsp_c unchanged and both rsp valids 0 in cycles without a delivered product; no output backpressure (requesters always sink).
REQ-018 SHALL maintain in-flight counter 0..LATENCY+1: +1 on accept, -1 on rsp delivery, both in same cycle = no change; busy = (count != 0).
REQ-019 SHALL set err (sticky until reset) when mul_out_en is high with head tag invalid, or head tag valid with mul_out_en low; mismatched product SHALL be dropped (no rsp valid).
REQ-020 SHALL sustain one accept per cycle indefinitely (back-to-back, alternating ids) with no bubbles.

Reset
REQ-021 SHALL on reset clear tag register, counter, pointer (to 1), rsp0_valid, rsp1_valid, rsp_c (0), err, busy; reqN_ready 0 while reset high.
REQ-022 SHALL on reset mid-operation discard all in-flight products; any mul_out_en in the first LATENCY cycles after reset release SHALL be ignored without setting err only if the multiplier is reset together (its out_en is then low).

Configuration
REQ-023 SHALL define ARB_RR_EN: defined -> round-robin per REQ-013; undefined -> fixed priority, requester 0 always wins ties, pointer logic absent.

Verification
REQ-024 SHALL test: reset, req0 only a=(0x4000,0x0000) b=(0x4000,0x0000) -> req0_ready same cycle, rsp0_valid 4 cycles later, rsp_c=(0x2000,0x0000), rsp1_valid 0.
REQ-025 SHALL test: both valid continuously 8 cycles (ARB_RR_EN) -> grants 0,1,0,1,...; rsp valids alternate 0,1,... from cycle 4; busy high throughout, low 4 cycles after last accept.
REQ-026 SHALL test: same as REQ-025 without ARB_RR_EN -> req1_ready never high; 8 rsp0_valid pulses.
REQ-027 SHALL test: req1 a=(0x0000,0x4000) b=(0x0000,0x4000) (j*j scaled) -> rsp1_valid, rsp_c=(0xE000,0x0000).
REQ-028 SHALL test: reset asserted 2 cycles after 2 accepts, multiplier also reset -> no rsp valid ever, err 0, busy 0 after reset.
REQ-029 SHALL test: force mul_out_en high with no accept -> err rises next cycle and stays 1; no rsp valid.
